clk_period_meter: RTL and testbench
===================================

Name: clk_period_meter

Overview:
- Consumer stage for divided clocks such as the 3:1 divider output.
- Samples an externally generated divided clock `clk_in` in the `clk` domain, then measures one full period and its high time in `clk` cycles.
- Reports both measurements with a one-cycle `done` pulse.
- Used to self-check divider ratios and duty cycle on chip and in simulation.

Parameters:
- CNT_W, 16, width of the measurement counter and of the `period`/`high_time` outputs.
- SYNC_STAGES, 2, number of synchronizer flops on `clk_in`; legal values are 2..4.

Ports:
- clk  input  1  system clock; sole clock of the block, all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- clk_in  input  1  divided clock under test; treated as asynchronous and always passed through the synchronizer.
- start  input  1  single-cycle request to begin a measurement.
- busy  output  1  high while a measurement is in progress.
- done  output  1  one-cycle pulse when a result or a timeout is available.
- timeout  output  1  qualifies `done`: 1 means the measurement was aborted by counter saturation.
- period  output  CNT_W  sampled clk cycles from one rising edge of `clk_in` to the next.
- high_time  output  CNT_W  sampled clk cycles for which `clk_in` was high within that period.

Behaviour:
- Reset: one clock, synchronous, active-high (`clk`, `reset`). On `reset`=1 at a clk edge:
  - state goes to IDLE; synchronizer flops, edge-history flop and counter clear to 0.
  - `busy`=0, `done`=0, `timeout`=0, `period`=0, `high_time`=0.
  - Reset has priority over everything. Reset mid-measurement aborts with no `done` pulse.
- Synchronizer and edge detect:
  - `s` is the last synchronizer stage; `s_d` is `s` delayed by one cycle.
  - rise = `s` & ~`s_d`; fall = ~`s` & `s_d`.
  - Edge-detect latency is SYNC_STAGES+1 cycles after `clk_in` changes.
- States: IDLE, ARM, HIGH, LOW.
  - IDLE: `busy`=0. If `start`=1, then cnt<=0 and go to ARM. `start` is ignored in every other state.
  - ARM: waits for the first rise. Any pulse or level already in progress is discarded.
    - On rise: cnt<=1, go to HIGH.
    - Otherwise cnt<=cnt+1.
  - HIGH: cnt<=cnt+1 each cycle.
    - On fall: `high_time`<=cnt, go to LOW (the counter keeps running).
    - `high_time` is therefore the number of cycles between the rise-detect cycle and the fall-detect cycle.
  - LOW: cnt<=cnt+1 each cycle.
    - On rise: `period`<=cnt, `done`<=1, `timeout`<=0, go to IDLE. See the optional feature for the alternative.
- `busy` = (state != IDLE), registered.
- `done` is asserted on the cycle after the closing rise detect and lasts exactly one cycle.
- `period` and `high_time` hold their last values until the next `done`.
- Saturation / timeout: if cnt = 2^CNT_W-1 in ARM, HIGH or LOW and the cycle is not an edge-completion cycle:
  - `done`<=1, `timeout`<=1; `period` and `high_time` are cleared to 0; go to IDLE. No wrap-around is permitted.
- Simultaneous events:
  - Timeout and a completing rise in the same cycle: the rise wins and the result is valid.
  - rise and fall in the same cycle is impossible by construction.
- `start` arriving in the same cycle as `done`: ignored, because state is not yet IDLE.
- `clk_in` stuck at 0 or 1: ends in timeout, never a hang.
- Arithmetic: unsigned, CNT_W bits. `high_time` <= `period` always holds for valid results.

Optional Feature:
- Macro: CLK_PERIOD_METER_CONTINUOUS_EN.
- Defined: on the completing rise in LOW, the block does not return to IDLE.
  - It pulses `done`, sets cnt<=1 and goes directly to HIGH, so each closing rise opens the next period.
  - `busy` stays 1, and results update every `clk_in` period.
  - Only `reset` or a timeout returns the block to IDLE. A timeout returns it to IDLE with `timeout`=1.
- Not defined: single-shot behaviour as specified above.

Test Plan:
- After reset, `clk_in` toggling with high 2 and low 3 clk cycles; `start` pulse -> `busy`=1; one `done` pulse with `period`=5, `high_time`=2, `timeout`=0; then `busy`=0.
- `clk_in` driven by the 3:1 divider output from the same `clk` -> `period`=3 on every measurement; `high_time` is 1 or 2; repeated starts give consistent results.
- `clk_in` held at 0, CNT_W=4 -> `done`=1 with `timeout`=1, `period`=0, `high_time`=0, on the 16th cycle after `start`; `busy` falls.
- `start` pulsed while `busy` (mid-HIGH) -> no restart; the result matches the undisturbed measurement.
- `reset` asserted during LOW -> no `done` pulse; all outputs are 0 on the next cycle; a new `start` then measures correctly.
- With CLK_PERIOD_METER_CONTINUOUS_EN and `clk_in` high 4 / low 4 -> `done` every 8 cycles, `period`=8, `high_time`=4, `busy` held at 1.

Source files
------------

// File: rtl/clk_period_meter.sv
// clk_period_meter: synchronizes an externally divided clock (clk_in) into the
// clk domain and measures one full period plus its high time in clk cycles.
// Results are reported with a one-cycle done pulse; timeout qualifies done
// when the measurement counter saturated before the period completed.
// Optional build macro: CLK_PERIOD_METER_CONTINUOUS_EN -- when defined, the
// closing rise of each period immediately opens the next one, so results
// refresh every clk_in period until reset or a timeout.
module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_time_q, high_time_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;

    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   sat;

    // Synchronizer shift and edge detection on the last synchronizer stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], clk_in};
        s      = sync_q[SYNC_STAGES-1];
        s_d_d  = s;
        rise   = s & ~s_d_q;
        fall   = ~s & s_d_q;
        sat    = (cnt_q == CNT_MAX);
    end

    // Measurement FSM: next state, counter and result updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ARM;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            ARM: begin
                // Anything in progress at start is discarded: only a fresh
                // rise opens the measured period.
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = HIGH;
                end else if (sat) begin
                    done_d      = 1'b1;
                    timeout_d   = 1'b1;
                    period_d    = CNT_ZERO;
                    high_time_d = CNT_ZERO;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (fall) begin
                    high_time_d = cnt_q;
                    cnt_d       = cnt_q + CNT_ONE;
                    state_d     = LOW;
                end else if (sat) begin
                    done_d      = 1'b1;
                    timeout_d   = 1'b1;
                    period_d    = CNT_ZERO;
                    high_time_d = CNT_ZERO;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LOW: begin
                // A completing rise wins over saturation in the same cycle.
                if (rise) begin
                    period_d  = cnt_q;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
`ifdef CLK_PERIOD_METER_CONTINUOUS_EN
                    cnt_d     = CNT_ONE;
                    state_d   = HIGH;
`else
                    state_d   = IDLE;
`endif
                end else if (sat) begin
                    done_d      = 1'b1;
                    timeout_d   = 1'b1;
                    period_d    = CNT_ZERO;
                    high_time_d = CNT_ZERO;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sync_q      <= {SYNC_STAGES{1'b0}};
            s_d_q       <= 1'b0;
            cnt_q       <= CNT_ZERO;
            period_q    <= CNT_ZERO;
            high_time_q <= CNT_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            s_d_q       <= s_d_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign period    = period_q;
    assign high_time = high_time_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed self-checking bench for clk_period_meter: a default-width instance
// for measurements and a CNT_W=4 instance for counter saturation.
// Define CLK_PERIOD_METER_CONTINUOUS_EN for both RTL and bench to exercise
// the continuous mode.
module tb_clk_period_meter;

    logic        clk;
    logic        reset;
    logic        clk_in;
    logic        start;
    logic        start_s;

    logic        busy_m, done_m, timeout_m;
    logic [15:0] period_m, high_time_m;
    logic        busy_s, done_s, timeout_s;
    logic [3:0]  period_s, high_time_s;

    logic        gen_en;
    int          gen_hi;
    int          gen_lo;
    int          gen_ph;

    int          n_pass;
    int          n_checks;

    clk_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) u_main (
        .clk(clk), .reset(reset), .clk_in(clk_in), .start(start),
        .busy(busy_m), .done(done_m), .timeout(timeout_m),
        .period(period_m), .high_time(high_time_m)
    );

    clk_period_meter #(.CNT_W(4), .SYNC_STAGES(2)) u_sat (
        .clk(clk), .reset(reset), .clk_in(clk_in), .start(start_s),
        .busy(busy_s), .done(done_s), .timeout(timeout_s),
        .period(period_s), .high_time(high_time_s)
    );

    // 10 time-unit system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divided-clock generator: high gen_hi / low gen_lo clk cycles, changes
    // just after each rising clk edge; disabled means held low, phase reset.
    initial begin
        clk_in = 1'b0;
        gen_ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!gen_en) begin
                gen_ph = 0;
                clk_in = 1'b0;
            end else begin
                clk_in = (gen_ph < gen_hi);
                gen_ph = (gen_ph + 1 >= gen_hi + gen_lo) ? 0 : gen_ph + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Holds clk_in low long enough to flush the synchronizer, then starts the
    // generator and pulses start on the selected DUT. Returns at negedge 1.
    task automatic launch(input bit sel, input int hi, input int lo);
        gen_en = 1'b0;
        repeat (6) @(negedge clk);
        gen_hi = hi;
        gen_lo = lo;
        gen_en = 1'b1;
        if (sel) start_s = 1'b1;
        else start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        start_s = 1'b0;
    endtask

    // Steps negedges from index k0 until done is seen or the budget expires.
    task automatic wait_done(input bit sel, input int k0, input int budget, output int k);
        logic d;
        k = k0;
        d = 1'b0;
        while (!d && k < budget) begin
            @(negedge clk);
            k++;
            d = sel ? done_s : done_m;
        end
        check(sel ? "done_seen_sat" : "done_seen", 32'(d), 32'd1);
    endtask

    initial begin
        int k;
        int nd;
        n_pass   = 0;
        n_checks = 0;
        reset    = 1'b1;
        start    = 1'b0;
        start_s  = 1'b0;
        gen_en   = 1'b0;
        gen_hi   = 2;
        gen_lo   = 3;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy",    32'(busy_m),      32'd0);
        check("rst_done",    32'(done_m),      32'd0);
        check("rst_timeout", 32'(timeout_m),   32'd0);
        check("rst_period",  32'(period_m),    32'd0);
        check("rst_high",    32'(high_time_m), 32'd0);
        check("rst_busy_s",  32'(busy_s),      32'd0);
        check("rst_done_s",  32'(done_s),      32'd0);
        check("rst_period_s", 32'(period_s),   32'd0);

`ifdef CLK_PERIOD_METER_CONTINUOUS_EN
        // High 4 / low 4: first result at negedge 12, then every 8 cycles.
        launch(1'b0, 4, 4);
        check("cont_busy0", 32'(busy_m), 32'd1);
        k = 1;
        for (int i = 0; i < 3; i++) begin
            wait_done(1'b0, k, 12 + 8 * i + 4, k);
            check("cont_latency", 32'(k),           32'(12 + 8 * i));
            check("cont_period",  32'(period_m),    32'd8);
            check("cont_high",    32'(high_time_m), 32'd4);
            check("cont_timeout", 32'(timeout_m),   32'd0);
            check("cont_busy",    32'(busy_m),      32'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("cont_rst_busy", 32'(busy_m), 32'd0);
`else
        // High 2 / low 3: rise detected at edge 4, done at negedge 9.
        launch(1'b0, 2, 3);
        check("t1_busy", 32'(busy_m), 32'd1);
        wait_done(1'b0, 1, 40, k);
        check("t1_latency", 32'(k),           32'd9);
        check("t1_period",  32'(period_m),    32'd5);
        check("t1_high",    32'(high_time_m), 32'd2);
        check("t1_timeout", 32'(timeout_m),   32'd0);
        @(negedge clk);
        check("t1_done_pulse", 32'(done_m), 32'd0);
        check("t1_busy_after", 32'(busy_m), 32'd0);

        // 3:1 divider waveform, repeated starts.
        for (int i = 0; i < 3; i++) begin
            launch(1'b0, 1, 2);
            wait_done(1'b0, 1, 40, k);
            check("div3_latency", 32'(k),           32'd7);
            check("div3_period",  32'(period_m),    32'd3);
            check("div3_high",    32'(high_time_m), 32'd1);
            check("div3_timeout", 32'(timeout_m),   32'd0);
        end

        // start pulsed mid-HIGH (sampled at edge 7) must not restart.
        launch(1'b0, 6, 4);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, 7, 40, k);
        check("midstart_latency", 32'(k),           32'd14);
        check("midstart_period",  32'(period_m),    32'd10);
        check("midstart_high",    32'(high_time_m), 32'd6);

        // Reset while in LOW (edges 8..13) aborts with no done.
        launch(1'b0, 4, 6);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rl_busy",    32'(busy_m),      32'd0);
        check("rl_done",    32'(done_m),      32'd0);
        check("rl_timeout", 32'(timeout_m),   32'd0);
        check("rl_period",  32'(period_m),    32'd0);
        check("rl_high",    32'(high_time_m), 32'd0);
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_m) nd++;
        end
        check("rl_no_done", 32'(nd), 32'd0);
        launch(1'b0, 4, 6);
        wait_done(1'b0, 1, 40, k);
        check("rl_re_latency", 32'(k),           32'd14);
        check("rl_re_period",  32'(period_m),    32'd10);
        check("rl_re_high",    32'(high_time_m), 32'd4);

        // Valid measurement on the narrow instance so the timeout clear shows.
        launch(1'b1, 2, 3);
        wait_done(1'b1, 1, 40, k);
        check("sat_ok_latency", 32'(k),           32'd9);
        check("sat_ok_period",  32'(period_s),    32'd5);
        check("sat_ok_high",    32'(high_time_s), 32'd2);
`endif

        // clk_in stuck low on the CNT_W=4 instance: counter saturates.
        gen_en = 1'b0;
        repeat (6) @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        check("to_busy", 32'(busy_s), 32'd1);
        wait_done(1'b1, 1, 40, k);
        check("to_latency", 32'(k),           32'd17);
        check("to_timeout", 32'(timeout_s),   32'd1);
        check("to_period",  32'(period_s),    32'd0);
        check("to_high",    32'(high_time_s), 32'd0);
        @(negedge clk);
        check("to_busy_after", 32'(busy_s), 32'd0);
        check("to_done_pulse", 32'(done_s), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
